// File: rtl/ama_riscv_trace_pkg.sv
// Shared types and constants for the ama-riscv retire-trace stream.
// Entry layout and word0 packing used by the transmitter.
package ama_riscv_trace_pkg;

  localparam logic [3:0] TRACE_TAG     = 4'hA;
  localparam int         TRACE_WORDS   = 4;
  localparam int         TRACE_DELTA_W = 20;

  typedef enum logic [1:0] {
    HW_NONE = 2'd0,
    HW_HIT  = 2'd1,
    HW_MISS = 2'd2,
    HW_RSVD = 2'd3
  } hw_status_t;

  typedef struct packed {
    logic [31:0]              pc;
    logic [31:0]              inst;
    logic [31:0]              sp;
    hw_status_t               ic_hm;
    hw_status_t               dc_hm;
    hw_status_t               bp_hm;
    logic                     br_taken;
    logic                     ovf;
    logic [TRACE_DELTA_W-1:0] delta;
  } trace_entry_t;

  function automatic logic [31:0] trace_word0(trace_entry_t e);
    return {TRACE_TAG, e.ic_hm, e.dc_hm, e.bp_hm,
            e.br_taken, e.ovf, e.delta};
  endfunction

endpackage

// File: rtl/ama_riscv_trace_fifo.sv
// Synchronous FIFO of trace entries with extra-MSB pointers.
// Caller guarantees push only when not full or popping.
module ama_riscv_trace_fifo
  import ama_riscv_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  trace_entry_t             din_i,
  output trace_entry_t             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  trace_entry_t mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i) wptr_d = wptr_q + ONE;
    if (pop_i)  rptr_d = rptr_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;

endmodule

// File: rtl/ama_riscv_trace_tx.sv
// Retire-trace transmitter: captures retire events into a FIFO
// and streams each entry as four 32-bit words over valid/ready.
module ama_riscv_trace_tx
  import ama_riscv_trace_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DELTA_W = TRACE_DELTA_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ret_valid,
  input  logic [31:0] ret_pc,
  input  logic [31:0] ret_inst,
  input  logic [31:0] ret_sp,
  input  logic [1:0]  ret_ic_hm,
  input  logic [1:0]  ret_dc_hm,
  input  logic [1:0]  ret_bp_hm,
  input  logic        ret_br_taken,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [15:0] drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [DELTA_W-1:0] CYC_MAX  = '1;
  localparam logic [15:0]        DROP_MAX = 16'hFFFF;

  trace_entry_t       entry, head;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_cnt;
  logic               capture, hs, pop, space, push, drop;
  logic [DELTA_W-1:0] cyc_q, cyc_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        drop_q, drop_d;
  logic [1:0]         widx_q, widx_d;

  assign capture = en && ret_valid;
  assign hs      = out_valid && out_ready;
  assign pop     = hs && (widx_q == 2'd3);
  // A word3 pop frees the head slot in the same cycle.
  assign space   = !fifo_full || pop;
  assign push    = capture && space;
  assign drop    = capture && !space;

  always_comb begin
    entry          = '0;
    entry.pc       = ret_pc;
    entry.inst     = ret_inst;
    entry.sp       = ret_sp;
    entry.ic_hm    = hw_status_t'(ret_ic_hm);
    entry.dc_hm    = hw_status_t'(ret_dc_hm);
    entry.bp_hm    = hw_status_t'(ret_bp_hm);
    entry.br_taken = ret_br_taken;
    entry.ovf      = ovf_q;
    entry.delta    = cyc_q;
  end

  ama_riscv_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (entry),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    cyc_d  = cyc_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    widx_d = widx_q;
    if (en) begin
      if (push)                 cyc_d = DELTA_W'(1);
      else if (cyc_q != CYC_MAX) cyc_d = cyc_q + DELTA_W'(1);
    end
    if (push)      ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;
    if (drop && drop_q != DROP_MAX) drop_d = drop_q + 16'd1;
    if (hs) widx_d = widx_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
      widx_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
      widx_q <= widx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (fifo_full == (fifo_cnt == CW'(DEPTH)));
  end

  assign out_valid = !fifo_empty;
  assign out_last  = out_valid && (widx_q == 2'd3);
  assign drop_cnt  = drop_q;

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      case (widx_q)
        2'd0:    out_data = trace_word0(head);
        2'd1:    out_data = head.pc;
        2'd2:    out_data = head.inst;
        default: out_data = head.sp;
      endcase
    end
  end

endmodule

// File: tb/tb_ama_riscv_trace_tx.sv
// Directed self-checking bench for ama_riscv_trace_tx.
module tb_ama_riscv_trace_tx;

  logic        clk = 1'b0;
  logic        rst, en, ret_valid, ret_br_taken, out_ready;
  logic [31:0] ret_pc, ret_inst, ret_sp;
  logic [1:0]  ret_ic_hm, ret_dc_hm, ret_bp_hm;
  logic        out_valid, out_last;
  logic [31:0] out_data;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ama_riscv_trace_tx #(.DEPTH(8), .DELTA_W(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .ret_valid    (ret_valid),
    .ret_pc       (ret_pc),
    .ret_inst     (ret_inst),
    .ret_sp       (ret_sp),
    .ret_ic_hm    (ret_ic_hm),
    .ret_dc_hm    (ret_dc_hm),
    .ret_bp_hm    (ret_bp_hm),
    .ret_br_taken (ret_br_taken),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .drop_cnt     (drop_cnt)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ret(input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] sp);
    ret_pc   = pc;
    ret_inst = inst;
    ret_sp   = sp;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ret_valid = 1'b0; out_ready = 1'b0;
    ret_ic_hm = 2'd0; ret_dc_hm = 2'd0; ret_bp_hm = 2'd0;
    ret_br_taken = 1'b0;
    set_ret(32'h0, 32'h0, 32'h0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", out_data);
    end
    checks++;
    if (out_last !== 1'b0) begin
      errors++; $display("FAIL reset_last: got %b expected 0", out_last);
    end
    checks++;
    if (drop_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_drop: got %h expected 0", drop_cnt);
    end
  endtask

  task automatic test_single();
    logic [31:0] exp [4];
    exp[0] = 32'hA800_0000; exp[1] = 32'h40;
    exp[2] = 32'h0050_0093; exp[3] = 32'h1000;
    do_reset();
    en = 1'b1; out_ready = 1'b1; ret_valid = 1'b1;
    set_ret(32'h40, 32'h0050_0093, 32'h1000);
    ret_ic_hm = 2'd2;
    step();
    ret_valid = 1'b0; ret_ic_hm = 2'd0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[k]) begin
        errors++;
        $display("FAIL single_word%0d: got v=%b %h expected v=1 %h",
                 k, out_valid, out_data, exp[k]);
      end
      checks++;
      if (out_last !== (k == 3)) begin
        errors++;
        $display("FAIL single_last%0d: got %b expected %b",
                 k, out_last, (k == 3));
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_two_retires();
    do_reset();
    en = 1'b1; out_ready = 1'b1; ret_valid = 1'b1;
    set_ret(32'h80, 32'h1, 32'h2000);
    step();
    ret_valid = 1'b0;
    step();
    step();
    ret_valid = 1'b1;
    set_ret(32'h84, 32'h2, 32'h2004);
    ret_dc_hm = 2'd1; ret_bp_hm = 2'd3; ret_br_taken = 1'b1;
    step();
    ret_valid = 1'b0;
    ret_dc_hm = 2'd0; ret_bp_hm = 2'd0; ret_br_taken = 1'b0;
    checks++;
    if (out_last !== 1'b1 || out_data !== 32'h2000) begin
      errors++;
      $display("FAIL two_first_w3: got last=%b %h expected last=1 2000",
               out_last, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA1E0_0003) begin
      errors++;
      $display("FAIL two_delta: got v=%b %h expected v=1 a1e00003",
               out_valid, out_data);
    end
    step();
    checks++;
    if (out_data !== 32'h84) begin
      errors++; $display("FAIL two_pc: got %h expected 84", out_data);
    end
    step(); step(); step();
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ret_valid = 1'b1;
      set_ret(32'h100 + 32'(i * 4), 32'(i), 32'h3000 + 32'(i));
      step();
    end
    ret_valid = 1'b0; en = 1'b0;
    checks++;
    if (drop_cnt !== 16'd2) begin
      errors++; $display("FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt);
    end
    out_ready = 1'b1;
    for (int e = 0; e < 8; e++) begin
      for (int w = 0; w < 4; w++) begin
        case (w)
          0:       exp = (e == 0) ? 32'hA000_0000 : 32'hA000_0001;
          1:       exp = 32'h100 + 32'(e * 4);
          2:       exp = 32'(e);
          default: exp = 32'h3000 + 32'(e);
        endcase
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
          errors++;
          $display("FAIL ovf_drain e%0d w%0d: got v=%b %h expected %h",
                   e, w, out_valid, out_data, exp);
        end
        step();
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_empty: got %b expected 0", out_valid);
    end
    en = 1'b1; ret_valid = 1'b1;
    set_ret(32'h500, 32'h55, 32'h3500);
    step();
    ret_valid = 1'b0;
    checks++;
    if (out_data !== 32'hA010_0003) begin
      errors++;
      $display("FAIL ovf_flag_delta: got %h expected a0100003", out_data);
    end
    step(); step(); step(); step();
    checks++;
    if (drop_cnt !== 16'd2 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_after: got drop=%0d v=%b expected drop=2 v=0",
               drop_cnt, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; out_ready = 1'b1; ret_valid = 1'b1;
    set_ret(32'h600, 32'h66, 32'h3600);
    step();
    ret_valid = 1'b0;
    step();
    checks++;
    if (out_data !== 32'h600) begin
      errors++; $display("FAIL mid_word1: got %h expected 600", out_data);
    end
    rst = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_rst: got v=%b drop=%0d expected v=0 drop=0",
               out_valid, drop_cnt);
    end
    rst = 1'b0;
    step();
    step();
    ret_valid = 1'b1;
    set_ret(32'h700, 32'h77, 32'h3700);
    step();
    ret_valid = 1'b0;
    checks++;
    if (out_data !== 32'hA000_0002 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_delta: got %h last=%b expected a0000002 last=0",
               out_data, out_last);
    end
    step(); step(); step();
    checks++;
    if (out_data !== 32'h3700 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL mid_w3: got %h last=%b expected 3700 last=1",
               out_data, out_last);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [8];
    logic [31:0] held;
    logic        stalled;
    int          n;
    exp[0] = 32'hA000_0000; exp[1] = 32'h900;
    exp[2] = 32'h91;        exp[3] = 32'h3900;
    exp[4] = 32'hA000_0001; exp[5] = 32'h904;
    exp[6] = 32'h92;        exp[7] = 32'h3904;
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    ret_valid = 1'b1; set_ret(32'h900, 32'h91, 32'h3900); step();
    ret_valid = 1'b1; set_ret(32'h904, 32'h92, 32'h3904); step();
    ret_valid = 1'b0;
    n = 0; stalled = 1'b0; held = '0;
    for (int t = 0; t < 40 && n < 8; t++) begin
      out_ready = t[0];
      if (out_valid) begin
        if (stalled) begin
          checks++;
          if (out_data !== held) begin
            errors++;
            $display("FAIL bp_stable: got %h expected %h", out_data, held);
          end
        end
        if (out_ready) begin
          checks++;
          if (out_data !== exp[n]) begin
            errors++;
            $display("FAIL bp_word%0d: got %h expected %h",
                     n, out_data, exp[n]);
          end
          n++;
        end
        stalled = !out_ready;
        held    = out_data;
      end else begin
        stalled = 1'b0;
      end
      step();
    end
    checks++;
    if (n != 8 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: got %0d words v=%b expected 8 v=0",
               n, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pushpop();
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ret_valid = 1'b1;
      set_ret(32'hA00 + 32'(i * 4), 32'(i), 32'h4000 + 32'(i));
      step();
    end
    ret_valid = 1'b0;
    out_ready = 1'b1;
    step(); step(); step();
    checks++;
    if (out_last !== 1'b1) begin
      errors++; $display("FAIL full_w3: got last=%b expected 1", out_last);
    end
    ret_valid = 1'b1;
    set_ret(32'hB00, 32'hBB, 32'h4B00);
    step();
    ret_valid = 1'b0;
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++; $display("FAIL full_drop: got %0d expected 0", drop_cnt);
    end
    for (int e = 0; e < 8; e++) begin
      if (e == 7) begin
        checks++;
        if (out_data !== 32'hA000_0004) begin
          errors++;
          $display("FAIL full_new_w0: got %h expected a0000004", out_data);
        end
      end
      step();
      checks++;
      if (out_data !== ((e == 7) ? 32'hB00 : 32'hA04 + 32'(e * 4))) begin
        errors++;
        $display("FAIL full_drain e%0d: got %h expected %h", e, out_data,
                 (e == 7) ? 32'hB00 : 32'hA04 + 32'(e * 4));
      end
      step(); step(); step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL full_empty: got %b expected 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_retires();
    test_overflow();
    test_reset_mid();
    test_backpressure();
    test_full_pushpop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ama_riscv_trace_tx.md
# ama_riscv_trace_tx

Hardware retire-trace transmitter for the ama-riscv core. Every cycle in which the core retires an instruction, it captures one trace entry: PC, instruction, stack pointer (x2), and hit/miss/branch status. Entries are buffered in a small FIFO and streamed out as four 32-bit words over a valid/ready interface. It is the producer side of the trace-entry stream that the cosim trace consumer reads, so the same trace can be collected from FPGA or emulation builds without DPI.

## Interface
Parameters:
- `DEPTH`, 8: FIFO depth in entries; power of two, at least 2.
- `DELTA_W`, 20: width of the cycle-delta field in word0; fixed at 20 for format v1.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  capture enable. While 0, no entries are captured, but draining continues.
- `ret_valid`  in  1  an instruction retires this cycle (core drives `!inst_wb_nop_or_clear`).
- `ret_pc`  in  32  PC of the retiring instruction.
- `ret_inst`  in  32  retiring instruction word.
- `ret_sp`  in  32  value of x2 this cycle.
- `ret_ic_hm`  in  2  icache status, `hw_status_t`.
- `ret_dc_hm`  in  2  dcache status, `hw_status_t`.
- `ret_bp_hm`  in  2  branch predictor status, `hw_status_t`.
- `ret_br_taken`  in  1  branch taken.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  sink accepts the word.
- `out_data`  out  32  stream word.
- `out_last`  out  1  marks word3 of an entry.
- `drop_cnt`  out  16  saturating count of dropped entries.

## Operation
- Capture event: `en && ret_valid`. On a capture event the entry is pushed if the FIFO has space, otherwise it is dropped.
  - "Has space" means `count < DEPTH`, or a pop occurs in the same cycle.
- Cycle-delta counter `cyc_cnt` (`DELTA_W` bits, reset 0). It only updates while `en`=1:
  - On a push: the stored delta is `cyc_cnt`, and `cyc_cnt` is set to 1.
  - Otherwise: `cyc_cnt` increments, saturating at 20'hFFFFF.
  - A dropped entry does not reset `cyc_cnt`. The delta is always measured from the last stored entry.
- Overflow flag `ovf` (sticky, reset 0):
  - Set on a drop.
  - Copied into the next pushed entry, then cleared in that same cycle.
- Drops: `drop_cnt` increments on every drop and saturates at 16'hFFFF.
- Word format, emitted in order:
  - word0 = {`TRACE_TAG`=4'hA, ic_hm[1:0], dc_hm[1:0], bp_hm[1:0], br_taken, ovf, delta[19:0]}
  - word1 = pc
  - word2 = inst
  - word3 = sp
- Serializer: word index `widx` counts 0..3 (reset 0).
  - `out_valid` = FIFO not empty.
  - `out_data` = word[`widx`] of the FIFO head.
  - `out_last` = `out_valid && widx==3`.
  - A handshake (`out_valid && out_ready`) advances `widx`. The handshake on word3 pops the head and wraps `widx` to 0.
- Stream rules: once `out_valid` is asserted, it and `out_data` remain stable until accepted. There is no combinational path from `out_ready` to `out_valid` or `out_data`.
- `hw_status_t` encoding: none=2'd0, hit=2'd1, miss=2'd2, 2'd3 reserved (passed through unchanged).

## Timing
- All outputs reset to 0 at the first posedge with `rst`=1:
  - FIFO emptied, `widx`=0, `cyc_cnt`=0, `ovf`=0, `drop_cnt`=0.
  - Reset mid-entry abandons any partially sent entry; no completion words are emitted.
- Latency: a capture sampled at posedge N into an empty FIFO gives `out_valid`=1 with word0 after posedge N (same cycle as N+1 logic). One cycle of latency, registered.
- Throughput:
  - Full rate is 1 entry per 4 cycles with `out_ready` held at 1.
  - Sustained retire at more than 1/4 IPC fills the FIFO, then drops.
- Simultaneous push and word3 pop when full: both take effect, `count` stays at `DEPTH`, no drop.
- Pointer wrap: read and write pointers are `log2(DEPTH)`+1 bits. Full/empty is derived from the MSB compare.
- `en` falling: captures stop immediately and `cyc_cnt` holds. Entries already queued still drain.

## Structure
- Shared package `ama_riscv_trace_pkg`:
  - `hw_status_t` enum
  - `trace_entry_t` packed struct (pc, inst, sp, ic/dc/bp hm, br_taken, ovf, delta)
  - `TRACE_TAG`, `TRACE_WORDS`=4, `TRACE_DELTA_W`=20
- Sub-module `ama_riscv_trace_fifo`: generic synchronous FIFO of `trace_entry_t`, parameterized by `DEPTH`, with push/pop/full/empty/count.
- The top level holds the capture logic, `cyc_cnt`, `ovf`, `drop_cnt` and the 4-word serializer.

## Test plan
- Single retire after reset: pc=0x40, inst=0x00500093, sp=0x1000, ic_hm=miss, `out_ready`=1.
  - Expect 4 words: 0xA800_0000 (delta 0), 0x40, 0x00500093, 0x1000.
  - `out_last` asserted only on the 4th word.
- Two retires 3 cycles apart, sink ready: second word0 delta=3 and ovf=0.
- `out_ready`=0 and 10 back-to-back retires with `DEPTH`=8:
  - 8 stored, `drop_cnt`=2.
  - After release, entry 9's successor (the next captured entry) has ovf=1; its delta counts from entry 8.
- Backpressure toggling `out_ready` every other cycle: `out_valid`/`out_data` stay stable while not ready, and words arrive in order with no duplicates.
- FIFO full with a word3 handshake and a retire in the same cycle: no drop, `count` stays 8.
- `rst` pulsed while word1 is presented:
  - The next cycle has `out_valid`=0 and `drop_cnt`=0.
  - The next retire emits delta counted from the reset release.
